// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
//   state_t           : divider FSM state encoding (IDLE, RUN)
//   DIV_ZERO_QUOTIENT : quotient reported for a zero divisor (all ones).
//                       It is held at 64 bits so that any divider up to
//                       64 bits wide can slice off the width it needs.
package div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/add_sub_core.sv
// Combinational ripple-carry adder/subtractor.
//   a, b : WIDTH-bit operands
//   sub  : 0 -> sum = a + b, 1 -> sum = a - b (computed as a + ~b + 1)
//   sum  : WIDTH-bit result
//   cout : carry out of the top bit; when subtracting it means "no borrow"
module add_sub_core #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Ripple the carry bit by bit. The sub select both inverts b and supplies
  // the +1 through the carry-in, giving two's-complement subtraction.
  always_comb begin
    logic carry;
    logic bx;
    sum   = '0;
    carry = sub;
    for (int i = 0; i < WIDTH; i++) begin
      bx     = b[i] ^ sub;
      sum[i] = a[i] ^ bx ^ carry;
      carry  = (a[i] & bx) | (a[i] & carry) | (bx & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/div_restoring_8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n          : clock and asynchronous active-low reset
//   start               : begin a division (accepted only when idle)
//   dividend, divisor   : WIDTH-bit unsigned operands, captured on accept
//   quotient, remainder : registered results, held until the next completion
//   busy                : high while a division is in progress
//   done                : one-cycle pulse when results become valid
//   div_by_zero         : set together with done when the divisor was zero
module div_restoring_8
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic             zero_div;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   next_p;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic             unused_msb;

  // Shift the next dividend bit into the running remainder.
  assign partial = {rem, dvd_sh[WIDTH-1]};

  add_sub_core #(
    .WIDTH(WIDTH + 1)
  ) u_trial (
    .a   (partial),
    .b   ({1'b0, dsr}),
    .sub (1'b1),
    .sum (trial),
    .cout(no_borrow)
  );

  // Keep the trial difference only when it did not borrow. Either way the
  // selected value is below the divisor, so its top bit is always zero.
  assign next_p     = no_borrow ? trial : partial;
  assign rem_next   = next_p[WIDTH-1:0];
  assign unused_msb = next_p[WIDTH];

  // Dividend bits leave at the top while quotient bits enter at the bottom,
  // so after WIDTH iterations the shift register holds the quotient.
  assign dvd_next = {dvd_sh[WIDTH-2:0], no_borrow};

  // Divider FSM: capture operands in IDLE, iterate in RUN, publish results
  // and pulse done on the last iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      dvd_sh      <= '0;
      dsr         <= '0;
      rem         <= '0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_sh      <= dividend;
            dsr         <= divisor;
            rem         <= '0;
            count       <= '0;
            zero_div    <= (divisor == '0);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (zero_div) begin
            // A zero divisor skips the iterations and finishes after one cycle.
            quotient    <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
            remainder   <= dvd_sh;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            rem    <= rem_next;
            dvd_sh <= dvd_next;
            count  <= count + 1'b1;
            if (count == CNT_W'(WIDTH - 1)) begin
              quotient  <= dvd_next;
              remainder <= rem_next;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_restoring_8.sv
// Directed testbench for div_restoring_8. Inputs change on the falling edge
// and outputs are sampled on the falling edge, away from the active edge.
module tb_div_restoring_8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks;
  int errors;

  div_restoring_8 #(
    .WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits from the current falling edge until done is seen, counting cycles
  // and the cycles in which busy was high. Bounded so it always returns.
  task automatic wait_done(output int lat, output int busy_cnt, output bit timeout);
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    timeout = (done !== 1'b1);
  endtask

  // Issues a one-cycle start and waits for completion.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int busy_cnt, output bit timeout);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_cnt, timeout);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    #2;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: got q=%0h r=%0h busy=%b done=%b dbz=%b expected all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    repeat (3) @(negedge clk);
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_held: got q=%0h r=%0h busy=%b done=%b dbz=%b expected all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    bit to;
    run_div(8'd200, 8'd7, lat, bc, to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL basic_timeout: done got 0 expected 1");
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d expected 8", lat);
    end
    checks++;
    if (bc != 8) begin
      errors++;
      $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", bc);
    end
    checks++;
    if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result: got q=%0d r=%0d dbz=%b busy=%b expected q=28 r=4 dbz=0 busy=0",
               quotient, remainder, div_by_zero, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4) begin
      errors++;
      $display("[TB] FAIL basic_done_pulse: got done=%b q=%0d r=%0d expected done=0 q=28 r=4",
               done, quotient, remainder);
    end
  endtask

  task automatic test_edges();
    int lat, bc;
    bit to;
    run_div(8'd255, 8'd1, lat, bc, to);
    checks++;
    if (to || quotient !== 8'd255 || remainder !== 8'd0) begin
      errors++;
      $display("[TB] FAIL edge_255_1: got q=%0d r=%0d timeout=%b expected q=255 r=0", quotient, remainder, to);
    end
    run_div(8'd5, 8'd9, lat, bc, to);
    checks++;
    if (to || quotient !== 8'd0 || remainder !== 8'd5) begin
      errors++;
      $display("[TB] FAIL edge_5_9: got q=%0d r=%0d timeout=%b expected q=0 r=5", quotient, remainder, to);
    end
    run_div(8'd255, 8'd255, lat, bc, to);
    checks++;
    if (to || quotient !== 8'd1 || remainder !== 8'd0) begin
      errors++;
      $display("[TB] FAIL edge_255_255: got q=%0d r=%0d timeout=%b expected q=1 r=0", quotient, remainder, to);
    end
    run_div(8'd0, 8'd13, lat, bc, to);
    checks++;
    if (to || quotient !== 8'd0 || remainder !== 8'd0) begin
      errors++;
      $display("[TB] FAIL edge_0_13: got q=%0d r=%0d timeout=%b expected q=0 r=0", quotient, remainder, to);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    bit to;
    run_div(8'd100, 8'd0, lat, bc, to);
    checks++;
    if (to || lat != 1 || bc != 1) begin
      errors++;
      $display("[TB] FAIL dz_latency: got lat=%0d busy_cycles=%0d timeout=%b expected lat=1 busy_cycles=1",
               lat, bc, to);
    end
    checks++;
    if (quotient !== 8'hFF || remainder !== 8'd100 || div_by_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dz_result: got q=%0h r=%0d dbz=%b expected q=ff r=100 dbz=1",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    dividend = 8'd10;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dz_clear_on_start: got dbz=%b busy=%b expected dbz=0 busy=1", div_by_zero, busy);
    end
    wait_done(lat, bc, to);
    checks++;
    if (to || quotient !== 8'd3 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dz_followup: got q=%0d r=%0d dbz=%b timeout=%b expected q=3 r=1 dbz=0",
               quotient, remainder, div_by_zero, to);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    bit to;
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'hAA;
    divisor  = 8'h01;
    wait_done(lat, bc, to);
    checks++;
    if (to || lat != 5) begin
      errors++;
      $display("[TB] FAIL ignore_latency: got lat=%0d timeout=%b expected lat=5", lat, to);
    end
    checks++;
    if (quotient !== 8'd28 || remainder !== 8'd4) begin
      errors++;
      $display("[TB] FAIL ignore_result: got q=%0d r=%0d expected q=28 r=4", quotient, remainder);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd28) begin
      errors++;
      $display("[TB] FAIL ignore_no_second_run: got busy=%b done=%b q=%0d expected busy=0 done=0 q=28",
               busy, done, quotient);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    bit to;
    bit saw_done;
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b expected all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got done/busy activity=1 expected 0");
    end
    run_div(8'd81, 8'd9, lat, bc, to);
    checks++;
    if (to || lat != 8 || quotient !== 8'd9 || remainder !== 8'd0) begin
      errors++;
      $display("[TB] FAIL abort_restart: got q=%0d r=%0d lat=%0d timeout=%b expected q=9 r=0 lat=8",
               quotient, remainder, lat, to);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit to;
    run_div(8'd81, 8'd9, lat, bc, to);
    checks++;
    if (to || quotient !== 8'd9 || remainder !== 8'd0) begin
      errors++;
      $display("[TB] FAIL b2b_first: got q=%0d r=%0d timeout=%b expected q=9 r=0", quotient, remainder, to);
    end
    dividend = 8'd17;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got done=%b busy=%b expected done=0 busy=1", done, busy);
    end
    wait_done(lat, bc, to);
    checks++;
    if (to || lat != 8) begin
      errors++;
      $display("[TB] FAIL b2b_latency: got lat=%0d timeout=%b expected lat=8", lat, to);
    end
    checks++;
    if (quotient !== 8'd3 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second: got q=%0d r=%0d dbz=%b expected q=3 r=2 dbz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] starting div_restoring_8 directed tests");
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_restoring_8.md
DIV_RESTORING_8 -- requirements
Module: div_restoring_8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a division, sampled on clk.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned numerator, captured when start is accepted.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned denominator, captured when start is accepted.
REQ-007 SHALL have port quotient  output  WIDTH  registered unsigned quotient.
REQ-008 SHALL have port remainder  output  WIDTH  registered unsigned remainder.
REQ-009 SHALL have port busy  output  1  high while a division is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking valid quotient and remainder.
REQ-011 SHALL have port div_by_zero  output  1  set with done when the captured divisor was zero.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; start SHALL be accepted only in IDLE.
REQ-013 SHALL ignore start while busy is 1, with no effect on the operation in progress or on the captured operands.
REQ-014 On acceptance at edge E0 with a nonzero divisor, the block SHALL enter RUN, set busy, and clear done and div_by_zero.
REQ-015 SHALL run unsigned restoring division, one quotient bit per cycle, MSB first, over edges E1..E(WIDTH).
REQ-016 Each iteration SHALL form a WIDTH+1-bit partial remainder as P = {R, next dividend bit}.
REQ-017 Each iteration SHALL compute the trial value T = P - {0, divisor} as P + ~{0, divisor} + 1.
REQ-018 If the carry-out is 1 (no borrow), the iteration SHALL set R = T and the quotient bit to 1; otherwise it SHALL keep R = P and set the quotient bit to 0.
REQ-019 At edge E(WIDTH), quotient, remainder and done=1 SHALL become valid, busy SHALL go to 0, and the state SHALL return to IDLE; total latency is WIDTH cycles from acceptance.
REQ-020 done SHALL be high for exactly one cycle.
REQ-021 A start sampled at edge E(WIDTH+1) SHALL be accepted, and done SHALL fall on that edge.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values until the next completion or reset; they SHALL not change during RUN.
REQ-023 If the captured divisor is 0, the block SHALL complete at E1 with quotient all-ones, remainder equal to the dividend, div_by_zero=1 and done=1, with busy high for one cycle.
REQ-024 The results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor.
REQ-025 Operand inputs SHALL be sampled only at acceptance; input changes during RUN SHALL not affect the result.

Reset
REQ-026 While rst_n=0, the state SHALL be IDLE and quotient, remainder, busy, done and div_by_zero SHALL all be 0, independent of clk.
REQ-027 Reset asserted during RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.
REQ-028 Internal shift and partial-remainder registers SHALL also clear on reset.

Structure
REQ-029 The FSM state encoding and a DIV_ZERO_QUOTIENT constant (all-ones) SHALL live in the shared package div_pkg.
REQ-030 The trial subtraction SHALL use one sub-module, add_sub_core: a combinational ripple adder/subtractor of parameterised width, instantiated at WIDTH+1 with its subtract select tied to 1 and its carry-out used as not-borrow.
REQ-031 All outputs SHALL be registered; no output SHALL be driven combinationally from an input.

Verification
REQ-032 Directed scenario: dividend=200, divisor=7, start 1 cycle -> busy for 8 cycles, then done pulse with quotient=28, remainder=4, div_by_zero=0.
REQ-033 Directed scenario: 255/1 -> quotient=255, remainder=0; and 5/9 -> quotient=0, remainder=5.
REQ-034 Directed scenario: 100/0 -> done one cycle after acceptance with quotient=8'hFF, remainder=100, div_by_zero=1; div_by_zero clears on the next accepted start.
REQ-035 Directed scenario: start 200/7, then pulse start with 9/3 and change the operands during RUN -> result stays 28/4, and the second request is not executed.
REQ-036 Directed scenario: start 200/7 and drive rst_n low at iteration 4 -> all outputs go to 0 immediately with no done; after release, 81/9 -> quotient=9, remainder=0.
REQ-037 Directed scenario: back-to-back 81/9 and 17/5, with start held in the cycle done is high -> second done exactly 8 cycles later with quotient=3, remainder=2.
